chacha_block_master: RTL and testbench

CHACHA_BLOCK_MASTER -- requirements
Module: chacha_block_master

---
 rtl/chacha_mem_pkg.sv | 28 ++
 rtl/chacha_rd_lat_pipe.sv | 43 ++++
 rtl/chacha_block_master.sv | 136 +++++++++++++
 tb/tb_chacha_block_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_mem_pkg.sv
// Shared definitions for the ChaCha20 block memory master.
//   - state_t            : controller state encoding
//   - DEF_*              : default geometry (address width, words per block, read latency)
//   - block_width()      : bits in one block of WORDS 32-bit words
//   - idx_width()        : bits needed to index a word inside a block
package chacha_mem_pkg;

  localparam int unsigned DEF_ADDR_W       = 15;
  localparam int unsigned DEF_WORDS        = 16;
  localparam int unsigned DEF_READ_LATENCY = 1;
  localparam int unsigned DEF_BLOCK_W      = 32 * DEF_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } state_t;

  function automatic int unsigned block_width(input int unsigned words);
    return 32 * words;
  endfunction

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/chacha_rd_lat_pipe.sv
// Read-latency tracker: shifts {valid, word index} through LATENCY stages so the
// controller knows which word avm_readdata carries on each cycle.
//   clk, reset_n      : clock, asynchronous active-low reset
//   clr               : synchronous clear (command cancelled)
//   in_valid, in_idx  : read address issued this cycle and its word index
//   out_valid, out_idx: readdata valid this cycle and the word it belongs to
module chacha_rd_lat_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned IDX_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [LATENCY-1:0] v_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) idx_q[i] <= '0;
    end else if (clr) begin
      v_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) idx_q[i] <= '0;
    end else begin
      v_q[0]   <= in_valid;
      idx_q[0] <= in_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        v_q[i]   <= v_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LATENCY-1];
  assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/chacha_block_master.sv
// Block transfer master: moves one WORDS x 32-bit ChaCha20 state between a
// command/response port and a fixed-latency Avalon-MM memory.
//   clk, reset_n                    : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             : command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_data   : direction, base word address, write block
//   abort                           : cancel the active transfer
//   rsp_valid/rsp_ready, rsp_data   : completion handshake, read block (zero for writes)
//   busy                            : any state but idle
//   avm_*                           : Avalon-MM master, no waitrequest, READ_LATENCY reads
module chacha_block_master
  import chacha_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned WORDS        = DEF_WORDS,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [32*WORDS-1:0]   cmd_data,
  input  logic                  abort,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*WORDS-1:0]   rsp_data,
  output logic                  busy,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [3:0]            avm_byteenable,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata
);

  localparam int unsigned BLK_W = block_width(WORDS);
  localparam int unsigned IDX_W = idx_width(WORDS);

  state_t            state, state_nxt;
  logic              wr_q;
  logic [ADDR_W-1:0] base_q;
  logic [BLK_W-1:0]  blk_q;
  logic [BLK_W-1:0]  rd_q;
  logic [IDX_W-1:0]  k_q;

  logic              accept;
  logic              last_k;
  logic              active;
  logic              push_rd;
  logic              capture;
  logic              pipe_v;
  logic [IDX_W-1:0]  pipe_idx;

  // cmd_ready follows reset_n directly so it reads 0 for the whole reset pulse.
  assign cmd_ready = (state == ST_IDLE) && reset_n;
  assign accept    = cmd_valid && cmd_ready;
  assign last_k    = (k_q == IDX_W'(WORDS - 1));
  assign active    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign push_rd   = (state == ST_ISSUE) && !wr_q;
  assign capture   = pipe_v && active && !abort;

  chacha_rd_lat_pipe #(
    .LATENCY (READ_LATENCY),
    .IDX_W   (IDX_W)
  ) u_lat_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (abort && active),
    .in_valid  (push_rd),
    .in_idx    (k_q),
    .out_valid (pipe_v),
    .out_idx   (pipe_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      wr_q   <= 1'b0;
      base_q <= '0;
      blk_q  <= '0;
      rd_q   <= '0;
      k_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q   <= cmd_write;
        base_q <= cmd_addr;
        blk_q  <= cmd_data;
        rd_q   <= '0;
        k_q    <= '0;
      end else if (state == ST_ISSUE) begin
        k_q <= k_q + 1'b1;
      end
      if (capture) rd_q[32*pipe_idx +: 32] <= avm_readdata;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (abort)       state_nxt = ST_IDLE;
        else if (last_k) state_nxt = wr_q ? ST_RESP : ST_DRAIN;
      end
      // Reads finish on capture of the final word; writes never reach here.
      ST_DRAIN: begin
        if (abort)                                             state_nxt = ST_IDLE;
        else if (capture && pipe_idx == IDX_W'(WORDS - 1))     state_nxt = ST_RESP;
      end
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = '0;
    avm_address    = '0;
    avm_writedata  = '0;
    if (state == ST_ISSUE) begin
      avm_chipselect = 1'b1;
      avm_write      = wr_q;
      avm_byteenable = '1;
      avm_address    = base_q + ADDR_W'(k_q);
      avm_writedata  = wr_q ? blk_q[32*k_q +: 32] : '0;
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = rsp_valid ? rd_q : '0;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_chacha_block_master.sv
// Self-checking bench for chacha_block_master: one instance at read latency 1
// and one at read latency 3 share a behavioural word memory.
module tb_chacha_block_master;
  import chacha_mem_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned NW = 16;
  localparam int unsigned BW = 32 * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset_n, cmd_valid, cmd_valid3, cmd_write, abort, rsp_ready;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_data;

  logic          cmd_ready1, rsp_valid1, busy1, cs1, wr1;
  logic [BW-1:0] rsp_data1;
  logic [AW-1:0] addr1;
  logic [3:0]    be1;
  logic [31:0]   wd1, rd1;

  logic          cmd_ready3, rsp_valid3, busy3, cs3, wr3;
  logic [BW-1:0] rsp_data3;
  logic [AW-1:0] addr3;
  logic [3:0]    be3;
  logic [31:0]   wd3, rd3;

  chacha_block_master #(.ADDR_W(AW), .WORDS(NW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .abort(abort),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .busy(busy1),
    .avm_address(addr1), .avm_chipselect(cs1), .avm_write(wr1), .avm_byteenable(be1),
    .avm_writedata(wd1), .avm_readdata(rd1));

  chacha_block_master #(.ADDR_W(AW), .WORDS(NW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .abort(abort),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .busy(busy3),
    .avm_address(addr3), .avm_chipselect(cs3), .avm_write(wr3), .avm_byteenable(be3),
    .avm_writedata(wd3), .avm_readdata(rd3));

  // Observation mux: sel picks which instance the directed steps look at.
  logic          sel;
  logic          o_cmd_ready, o_rsp_valid, o_busy, o_cs, o_wr;
  logic [BW-1:0] o_rsp_data;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_be;
  logic [31:0]   o_wd;
  assign o_cmd_ready = sel ? cmd_ready3 : cmd_ready1;
  assign o_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign o_busy      = sel ? busy3      : busy1;
  assign o_cs        = sel ? cs3        : cs1;
  assign o_wr        = sel ? wr3        : wr1;
  assign o_rsp_data  = sel ? rsp_data3  : rsp_data1;
  assign o_addr      = sel ? addr3      : addr1;
  assign o_be        = sel ? be3        : be1;
  assign o_wd        = sel ? wd3        : wd1;

  // Slave memory: writes land at the clock edge, reads return mem[address]
  // exactly L cycles after the address was presented, garbage otherwise.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  logic [3:0]    h1_v, h3_v;
  logic [AW-1:0] h1_a [4];
  logic [AW-1:0] h3_a [4];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (cs1 && wr1) mem[addr1] <= wd1;
    if (cs3 && wr3) mem[addr3] <= wd3;
    h1_v    <= {h1_v[2:0], cs1 & ~wr1};
    h3_v    <= {h3_v[2:0], cs3 & ~wr3};
    h1_a[0] <= addr1;
    h3_a[0] <= addr3;
    for (int i = 1; i < 4; i++) begin
      h1_a[i] <= h1_a[i-1];
      h3_a[i] <= h3_a[i-1];
    end
  end
  assign rd1 = h1_v[0] ? mem[h1_a[0]] : 32'hDEAD_BEEF;
  assign rd3 = h3_v[2] ? mem[h3_a[2]] : 32'hDEAD_BEEF;

  // Reference contents: what the bench intends memory to hold.
  logic [31:0] ref_mem [0:(1<<AW)-1];

  int unsigned checks = 0;
  int unsigned fails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int k = 0; k < NW; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [BW-1:0] ref_blk(input logic [AW-1:0] base);
    logic [BW-1:0] b;
    logic [AW-1:0] a;
    for (int k = 0; k < NW; k++) begin
      a = base + AW'(k);
      b[32*k +: 32] = ref_mem[a];
    end
    return b;
  endfunction

  task automatic preload(input logic [AW-1:0] base, input logic [BW-1:0] b);
    for (int k = 0; k < NW; k++) begin
      pl_en   = 1'b1;
      pl_addr = base + AW'(k);
      pl_data = b[32*k +: 32];
      ref_mem[pl_addr] = pl_data;
      tick();
    end
    pl_en = 1'b0;
  endtask

  // One complete command on the selected instance, checking every bus cycle,
  // response timing and data. stall: cycles rsp_ready stays low in RESP.
  // hold_next: keep cmd_valid high through RESP so the following call's
  // command is offered across the handshake.
  task automatic run_cmd(input bit use3, input bit wr, input logic [AW-1:0] base,
                         input logic [BW-1:0] blk, input int unsigned lat,
                         input int unsigned stall, input bit hold_next);
    int unsigned   n, t;
    logic [BW-1:0] exp_data, held;
    logic [AW-1:0] a;
    sel = use3;
    exp_data = wr ? '0 : ref_blk(base);
    cmd_write = wr;
    cmd_addr  = base;
    cmd_data  = blk;
    if (use3) cmd_valid3 = 1'b1; else cmd_valid = 1'b1;
    #1;
    chk("accept_ready", o_cmd_ready, 1);
    n = cyc;
    tick();
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_addr   = AW'($urandom);
    cmd_data   = rand_blk();
    cmd_write  = $urandom_range(0, 1);
    for (int k = 0; k < NW; k++) begin
      a = base + AW'(k);
      chk("issue_cs",    o_cs, 1);
      chk("issue_addr",  o_addr, a);
      chk("issue_write", o_wr, wr);
      chk("issue_busy",  o_busy, 1);
      chk("issue_rsp",   o_rsp_valid, 0);
      if (wr) begin
        chk("issue_be",    o_be, 4'hF);
        chk("issue_wdata", o_wd, blk[32*k +: 32]);
      end
      tick();
    end
    t = 0;
    while (o_rsp_valid !== 1'b1 && t < 64) begin
      tick();
      t++;
    end
    chk("rsp_seen", o_rsp_valid, 1);
    chk("rsp_cycle", 64'(cyc), 64'(n + NW + 1 + (wr ? 0 : lat)));
    chk_blk("rsp_data", o_rsp_data, exp_data);
    chk("resp_bus_idle", {o_cs, o_wr, o_be, o_addr, o_wd}, 0);
    held = o_rsp_data;
    for (int s = 0; s < int'(stall); s++) begin
      if (hold_next) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
      end
      abort = (s == 3);
      tick();
      abort = 1'b0;
      chk("stall_valid", o_rsp_valid, 1);
      chk_blk("stall_data", o_rsp_data, held);
      chk("stall_ready", o_cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("after_hs_valid", o_rsp_valid, 0);
    chk("after_hs_busy",  o_busy, 0);
    chk("after_hs_ready", o_cmd_ready, 1);
    if (wr)
      for (int k = 0; k < NW; k++) begin
        a = base + AW'(k);
        ref_mem[a] = blk[32*k +: 32];
      end
  endtask

  logic [BW-1:0] b;
  logic [AW-1:0] base;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_data = '0; abort = 1'b0; rsp_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0; sel = 1'b0;
    h1_v = '0; h3_v = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready1", cmd_ready1, 0);
    chk("rst_busy1",  busy1, 0);
    chk("rst_rsp1",   rsp_valid1, 0);
    chk_blk("rst_data1", rsp_data1, '0);
    chk("rst_bus1",   {cs1, wr1, be1, addr1, wd1}, 0);
    chk("rst_ready3", cmd_ready3, 0);
    chk("rst_bus3",   {cs3, wr3, be3, addr3, wd3}, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready1", cmd_ready1, 1);
    chk("rel_ready3", cmd_ready3, 1);
    tick();

    // Abort while idle is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ready", cmd_ready1, 1);

    // Read at 0x0100 after preloading 0xA0000000+k, latency 1 then 3.
    for (int k = 0; k < NW; k++) b[32*k +: 32] = 32'hA000_0000 + 32'(k);
    preload(15'h0100, b);
    run_cmd(0, 0, 15'h0100, rand_blk(), 1, 0, 0);
    chk_blk("ref_a0_block", ref_blk(15'h0100), b);
    run_cmd(1, 0, 15'h0100, rand_blk(), 3, 0, 0);

    // Write 0x11111111*k at 0x0200, read back.
    for (int k = 0; k < NW; k++) b[32*k +: 32] = 32'h1111_1111 * 32'(k);
    run_cmd(0, 1, 15'h0200, b, 1, 0, 0);
    run_cmd(0, 0, 15'h0200, rand_blk(), 1, 0, 0);
    chk_blk("readback_0200", ref_blk(15'h0200), b);

    // Address wrap.
    preload(15'h7FF8, rand_blk());
    run_cmd(0, 0, 15'h7FF8, rand_blk(), 1, 0, 0);

    // Response stall with cmd_valid held; next command accepted right after.
    base = AW'($urandom);
    run_cmd(0, 1, base, rand_blk(), 1, 10, 1);
    run_cmd(0, 0, base, rand_blk(), 1, 0, 0);

    // Abort at word 5.
    base = AW'($urandom);
    preload(base, rand_blk());
    sel = 1'b0;
    cmd_write = 1'b0; cmd_addr = base; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk("abort_addr", addr1, base + AW'(5));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_bus", {cs1, wr1, be1, addr1, wd1}, 0);
    chk("abort_busy", busy1, 0);
    chk("abort_ready", cmd_ready1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_rsp", rsp_valid1, 0);
    end

    // Reset pulse at word 9.
    cmd_addr = base; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (9) tick();
    chk("rst9_addr", addr1, base + AW'(9));
    reset_n = 1'b0;
    #1;
    chk("rst9_bus", {cs1, wr1, be1, addr1, wd1}, 0);
    chk("rst9_busy", busy1, 0);
    chk("rst9_ready", cmd_ready1, 0);
    chk("rst9_rsp", rsp_valid1, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst9_rel_ready", cmd_ready1, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst9_no_rsp", rsp_valid1, 0);
    end
    run_cmd(0, 0, base, rand_blk(), 1, 0, 0);

    // Randomized traffic: write then read back on both latencies.
    for (int i = 0; i < 4; i++) begin
      base = AW'($urandom);
      run_cmd(0, 1, base, rand_blk(), 1, $urandom_range(0, 3), 0);
      run_cmd(0, 0, base, rand_blk(), 1, $urandom_range(0, 3), 0);
      run_cmd(1, 0, base, rand_blk(), 3, 0, 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
